// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronizer, oversampled bit recovery, optional parity,
// one stop bit. Good words are presented on a one-cycle DATA_VALID strobe; parity
// and stop-bit failures are reported as one-cycle PAR_ERR / STP_ERR pulses.
//
// Build option: define UART_RX_MAJORITY_VOTE_EN to take each bit as the majority
// of three samples around the bit centre (decisions move one cycle later).
module uart_rx #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             RX_IN,
    input  logic [5:0]       PRESCALE,
    input  logic             PAR_EN,
    input  logic             PAR_TYP,
    output logic [WIDTH-1:0] P_DATA,
    output logic             DATA_VALID,
    output logic             PAR_ERR,
    output logic             STP_ERR
);

    localparam int unsigned BitCntW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    // Synchronizer and line-history registers
    logic       rx_meta_q;
    logic       rx_s_q;
    logic [1:0] sync_vld_q;
    logic       armed_q;

    // FSM, counters and frame datapath
    state_e             state_q, state_d;
    logic [5:0]         edge_cnt_q, edge_cnt_d;
    logic [BitCntW-1:0] bit_cnt_q, bit_cnt_d;
    logic [5:0]         prescale_q, prescale_d;
    logic               par_en_q, par_en_d;
    logic               par_typ_q, par_typ_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic               par_bad_q, par_bad_d;

    // Registered outputs
    logic [WIDTH-1:0] p_data_q, p_data_d;
    logic             data_valid_q, data_valid_d;
    logic             par_err_q, par_err_d;
    logic             stp_err_q, stp_err_d;

    logic sample_pt;
    logic bit_end;
    logic bit_val;

`ifdef UART_RX_MAJORITY_VOTE_EN
    // rx_hist_q[0] holds phase P/2, rx_hist_q[1] phase P/2-1 when the vote is taken
    logic [1:0] rx_hist_q;

    // Two-deep history of the synchronized line for the majority vote
    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_hist_q <= 2'b11;
        end else begin
            rx_hist_q <= {rx_hist_q[0], rx_s_q};
        end
    end

    assign sample_pt = (edge_cnt_q == ({1'b0, prescale_q[5:1]} + 6'd1));
    assign bit_val   = (rx_hist_q[1] & rx_hist_q[0]) | (rx_hist_q[1] & rx_s_q) |
                       (rx_hist_q[0] & rx_s_q);
`else
    assign sample_pt = (edge_cnt_q == {1'b0, prescale_q[5:1]});
    assign bit_val   = rx_s_q;
`endif

    assign bit_end = (edge_cnt_q == (prescale_q - 6'd1));

    // Synchronize RX_IN and arm start detection once a real idle-high level is seen
    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            sync_vld_q <= 2'b00;
            armed_q    <= 1'b0;
        end else begin
            rx_meta_q  <= RX_IN;
            rx_s_q     <= rx_meta_q;
            sync_vld_q <= {sync_vld_q[0], 1'b1};
            // The reset value of the synchronizer is not a line sample, so it
            // must not arm the receiver.
            armed_q    <= armed_q | (rx_s_q & sync_vld_q[1]);
        end
    end

    // State, datapath and output registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= StIdle;
            edge_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            prescale_q   <= '0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            shift_q      <= '0;
            par_bad_q    <= 1'b0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            edge_cnt_q   <= edge_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            prescale_q   <= prescale_d;
            par_en_q     <= par_en_d;
            par_typ_q    <= par_typ_d;
            shift_q      <= shift_d;
            par_bad_q    <= par_bad_d;
            p_data_q     <= p_data_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            stp_err_q    <= stp_err_d;
        end
    end

    // Next-state logic: frame sequencing, bit sampling and result pulses
    always_comb begin
        state_d      = state_q;
        edge_cnt_d   = bit_end ? 6'd0 : edge_cnt_q + 6'd1;
        bit_cnt_d    = bit_cnt_q;
        prescale_d   = prescale_q;
        par_en_d     = par_en_q;
        par_typ_d    = par_typ_q;
        shift_d      = shift_q;
        par_bad_d    = par_bad_q;
        p_data_d     = p_data_q;
        data_valid_d = 1'b0;
        par_err_d    = 1'b0;
        stp_err_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                edge_cnt_d = 6'd0;
                if (!rx_s_q && armed_q) begin
                    // This cycle is phase 0 of the start bit.
                    state_d    = StStart;
                    edge_cnt_d = 6'd1;
                    bit_cnt_d  = '0;
                    par_bad_d  = 1'b0;
                    prescale_d = PRESCALE;
                    par_en_d   = PAR_EN;
                    par_typ_d  = PAR_TYP;
                end
            end
            StStart: begin
                if (sample_pt && bit_val) begin
                    state_d    = StIdle;
                    edge_cnt_d = 6'd0;
                end else if (bit_end) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (sample_pt) begin
                    shift_d   = {bit_val, shift_q[WIDTH-1:1]};
                    bit_cnt_d = bit_cnt_q + BitCntW'(1);
                end
                if (bit_end && (bit_cnt_q == BitCntW'(WIDTH))) begin
                    state_d = par_en_q ? StParity : StStop;
                end
            end
            StParity: begin
                if (sample_pt && (bit_val != ((^shift_q) ^ par_typ_q))) begin
                    par_bad_d = 1'b1;
                end
                if (bit_end) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                if (sample_pt) begin
                    // Leave immediately so a start edge later in this bit is caught.
                    state_d    = StIdle;
                    edge_cnt_d = 6'd0;
                    if (!par_bad_q && bit_val) begin
                        p_data_d     = shift_q;
                        data_valid_d = 1'b1;
                    end else begin
                        par_err_d = par_bad_q;
                        stp_err_d = !bit_val;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign P_DATA     = p_data_q;
    assign DATA_VALID = data_valid_q;
    assign PAR_ERR    = par_err_q;
    assign STP_ERR    = stp_err_q;

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps

module tb_uart_rx;

`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam int V = 1;
`else
  localparam int V = 0;
`endif

  typedef struct {
    int         cyc;
    logic       dv;
    logic       pe;
    logic       se;
    logic [7:0] data;
  } ev_t;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       RX_IN = 1'b1;
  logic [5:0] PRESCALE = 6'd8;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_ERR;
  logic       STP_ERR;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  ev_t        obs_q[$];
  ev_t        exp_q[$];
  logic [7:0] last_good = 8'h00;

  uart_rx #(.WIDTH(8)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .RX_IN     (RX_IN),
    .PRESCALE  (PRESCALE),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .P_DATA    (P_DATA),
    .DATA_VALID(DATA_VALID),
    .PAR_ERR   (PAR_ERR),
    .STP_ERR   (STP_ERR)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Log every cycle that carries a pulse
  always @(negedge CLK) begin
    if (DATA_VALID || PAR_ERR || STP_ERR) begin
      ev_t e;
      e.cyc  = cyc;
      e.dv   = DATA_VALID;
      e.pe   = PAR_ERR;
      e.se   = STP_ERR;
      e.data = P_DATA;
      obs_q.push_back(e);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
      RX_IN = 1'b1;
    end
  endtask

  // spike_bit >= 0 inverts the line for one cycle at phase p/2 of that frame bit
  task automatic send_frame(input logic [7:0] data, input int p, input bit pen,
                            input bit ptyp, input bit par_flip, input bit stop_val,
                            input int spike_bit);
    logic [10:0] bits;
    int          n;
    int          c0;
    logic [7:0]  rxd;
    bit          par_bad;
    bit          stop_bad;
    ev_t         e;
    n    = 10 + int'(pen);
    bits = '0;
    for (int i = 0; i < 8; i++) bits[i+1] = data[i];
    if (pen) bits[9] = (^data) ^ ptyp ^ par_flip;
    bits[n-1] = stop_val;

    @(posedge CLK);
    #1;
    c0       = cyc;
    PRESCALE = 6'(p);
    PAR_EN   = pen;
    PAR_TYP  = ptyp;
    for (int i = 0; i < n * p; i++) begin
      if (i > 0) begin
        @(posedge CLK);
        #1;
      end
      RX_IN = bits[i/p] ^ (i == spike_bit * p + p / 2);
    end

    rxd = data;
    if (V == 0 && spike_bit >= 1 && spike_bit <= 8) rxd[spike_bit-1] = ~rxd[spike_bit-1];
    par_bad  = pen && (bits[9] != ((^rxd) ^ ptyp));
    stop_bad = !stop_val;
    // 2 synchronizer cycles, stop decision at (n-1)*p + p/2, pulse one later
    e.cyc = c0 + 2 + (n - 1) * p + p / 2 + 1 + V;
    e.dv  = !par_bad && !stop_bad;
    e.pe  = par_bad;
    e.se  = stop_bad;
    if (e.dv) last_good = rxd;
    e.data = last_good;
    exp_q.push_back(e);
  endtask

  initial begin
    int nmin;

    // Reset with the line already low: must not start a frame afterwards
    RST   = 1'b1;
    RX_IN = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    total++;
    if (P_DATA === 8'h00) passed++;
    else $error("FAIL reset_p_data: observed %0h", P_DATA);
    total++;
    if (DATA_VALID === 1'b0) passed++;
    else $error("FAIL reset_data_valid: observed %0h", DATA_VALID);
    total++;
    if (PAR_ERR === 1'b0) passed++;
    else $error("FAIL reset_par_err: observed %0h", PAR_ERR);
    total++;
    if (STP_ERR === 1'b0) passed++;
    else $error("FAIL reset_stp_err: observed %0h", STP_ERR);
    RST = 1'b0;
    repeat (60) @(posedge CLK);
    #1;
    idle(20);

    send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b0, 1'b1, -1);
    idle(4);
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    idle(16);
    repeat (3) begin
      @(posedge CLK);
      #1;
      RX_IN = 1'b0;
    end
    idle(20);
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    idle(4);
    send_frame(8'hA5, 16, 1'b1, 1'b1, 1'b1, 1'b1, -1);
    idle(3);
    send_frame(8'hA5, 16, 1'b1, 1'b1, 1'b0, 1'b1, -1);
    idle(5);
    send_frame(8'h3C, 16, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    send_frame(8'hC3, 16, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    idle(6);
    send_frame(8'hFF, 8, 1'b0, 1'b0, 1'b0, 1'b1, 4);
    idle(10);

    // Mid-frame reset: abort after start bit and part of the data
    PRESCALE = 6'd8;
    PAR_EN   = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge CLK);
      #1;
      RX_IN = (i < 8) ? 1'b0 : last_good[(i/8)-1] ^ 1'b1;
    end
    @(posedge CLK);
    #1;
    RST   = 1'b1;
    RX_IN = 1'b1;
    @(posedge CLK);
    #1;
    total++;
    if (P_DATA === 8'h00) passed++;
    else $error("FAIL midreset_p_data: observed %0h", P_DATA);
    total++;
    if (DATA_VALID === 1'b0) passed++;
    else $error("FAIL midreset_data_valid: observed %0h", DATA_VALID);
    total++;
    if (PAR_ERR === 1'b0) passed++;
    else $error("FAIL midreset_par_err: observed %0h", PAR_ERR);
    total++;
    if (STP_ERR === 1'b0) passed++;
    else $error("FAIL midreset_stp_err: observed %0h", STP_ERR);
    RST       = 1'b0;
    last_good = 8'h00;
    idle(200);

    for (int k = 0; k < 24; k++) begin
      logic [7:0] d;
      int         p;
      bit         pen;
      bit         ptyp;
      bit         flip;
      bit         stop;
      d    = 8'($urandom);
      p    = 8 + 2 * int'($urandom_range(0, 12));
      pen  = 1'($urandom_range(0, 1));
      ptyp = 1'($urandom_range(0, 1));
      flip = ($urandom_range(0, 3) == 0);
      stop = ($urandom_range(0, 4) != 0);
      send_frame(d, p, pen, ptyp, flip, stop, -1);
      // A bad stop bit leaves the line low; give the receiver a high bit
      if (!stop) idle(p + int'($urandom_range(0, 8)));
      else if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 2 * p)));
    end
    idle(400);

    total++;
    if (P_DATA === last_good) passed++;
    else $error("FAIL final_p_data: observed %0h, expected %0h", P_DATA, last_good);
    total++;
    if (obs_q.size() === exp_q.size()) passed++;
    else $error("FAIL pulse_count: observed %0d, expected %0d", obs_q.size(), exp_q.size());
    nmin = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < nmin; i++) begin
      total++;
      if (obs_q[i].cyc === exp_q[i].cyc) passed++;
      else $error("FAIL ev%0d_cycle: observed %0d, expected %0d", i, obs_q[i].cyc,
                  exp_q[i].cyc);
      total++;
      if (obs_q[i].dv === exp_q[i].dv) passed++;
      else $error("FAIL ev%0d_data_valid: observed %0h, expected %0h", i, obs_q[i].dv,
                  exp_q[i].dv);
      total++;
      if (obs_q[i].pe === exp_q[i].pe) passed++;
      else $error("FAIL ev%0d_par_err: observed %0h, expected %0h", i, obs_q[i].pe,
                  exp_q[i].pe);
      total++;
      if (obs_q[i].se === exp_q[i].se) passed++;
      else $error("FAIL ev%0d_stp_err: observed %0h, expected %0h", i, obs_q[i].se,
                  exp_q[i].se);
      total++;
      if (obs_q[i].data === exp_q[i].data) passed++;
      else $error("FAIL ev%0d_p_data: observed %0h, expected %0h", i, obs_q[i].data,
                  exp_q[i].data);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Receiver counterpart of the UART transmitter: recovers serial frames (start bit, WIDTH data bits LSB-first, optional even/odd parity bit, one stop bit) from an idle-high line using an oversampling clock. Parallel bytes are presented on a one-cycle `DATA_VALID` strobe, with parity and stop-bit error pulses. The block sits in the RX clock domain, in front of the data-sync / register-file path of the system.

## Interface
- `WIDTH`, 8, data bits per frame
- `CLK`  in  1  receiver oversampling clock
- `RST`  in  1  synchronous, active-high reset
- `RX_IN`  in  1  serial line, idle high, asynchronous to `CLK`
- `PRESCALE`  in  6  oversampling ratio; even values 8..32 supported
- `PAR_EN`  in  1  1 = parity bit present in the frame
- `PAR_TYP`  in  1  0 = even, 1 = odd
- `P_DATA`  out  WIDTH  last good received word
- `DATA_VALID`  out  1  one-cycle strobe, `P_DATA` is new
- `PAR_ERR`  out  1  one-cycle pulse, parity mismatch
- `STP_ERR`  out  1  one-cycle pulse, stop bit sampled 0

## Operation
- `RX_IN` passes through a 2-flop synchronizer; all logic below uses the synchronized value `rx_s`.
- An `armed` flag is cleared by reset and set the first cycle `rx_s`=1. Start detection requires `armed`, so a line already low at reset never starts a frame.
- The FSM has five states: IDLE, START, DATA, PARITY, STOP.
- IDLE to START when `rx_s`=0 and `armed`. `PRESCALE`, `PAR_EN` and `PAR_TYP` are latched on this cycle; later input changes have no effect until the next frame.
- `edge_cnt` counts 0..P-1 per bit (P = latched prescale). `bit_cnt` counts data bits.
- The sample point is `edge_cnt` = P/2.
- START: if the sample is 1, it is a glitch: return to IDLE with no output pulses. Otherwise go to DATA.
- DATA: each sample is shifted in LSB-first. After WIDTH bits, go to PARITY if `PAR_EN`, else to STOP.
- PARITY: the expected bit is XOR(data) for even and XNOR(data) for odd. A mismatch sets an internal error flag.
- STOP: on the stop decision cycle the FSM returns to IDLE immediately, so a following start edge in the same bit period is caught.
- On the cycle after the stop decision, the outputs update as follows:
  - no errors: `P_DATA` is loaded and `DATA_VALID`=1;
  - parity mismatch: `PAR_ERR`=1, and `STP_ERR` is also set if the stop bit is bad;
  - any error: `DATA_VALID` stays 0 and `P_DATA` holds its old value.
- `RST` asserted mid-frame aborts the frame: all state and outputs go to reset values and the synchronizer flops load 1.

## Timing
- Reset values:
  - `P_DATA`=0, `DATA_VALID`=0, `PAR_ERR`=0, `STP_ERR`=0;
  - FSM in IDLE, counters 0, `armed`=0.
- `RX_IN` to `rx_s`: 2 cycles.
- Cycle 0 is the IDLE cycle that sees `rx_s`=0. Bit k, phase j occupies cycle k·P + j.
- N = WIDTH + 2 + PAR_EN.
- The stop decision falls in cycle (N−1)·P + P/2. The output pulses fall in the following cycle.
- Each pulse is exactly one cycle wide. `DATA_VALID` and the error pulses never fall in the same cycle.
- Back-to-back frames with zero idle bits are received without loss at any supported P.

## Configuration
- `UART_RX_MAJORITY_VOTE_EN` defined:
  - each bit value is the majority of `rx_s` at phases P/2−1, P/2 and P/2+1;
  - the decision is taken at P/2+1, so every decision and output pulse moves 1 cycle later;
  - the start-glitch check uses the voted value.
- Undefined: single sample at P/2, with the timing stated above.

## Test plan
- P=8, `PAR_EN`=1, `PAR_TYP`=0, frame 0,10100101,0,1 (byte 0xA5) -> `DATA_VALID` at cycle 10·8+4+1=85 with `P_DATA`=0xA5, and no error pulses.
- P=16, `PAR_EN`=1, `PAR_TYP`=1, 0xA5 sent with parity bit 0 -> a `PAR_ERR` pulse, `DATA_VALID` stays 0, `P_DATA` unchanged. With parity bit 1 -> `DATA_VALID`, `P_DATA`=0xA5.
- P=8, `PAR_EN`=0, 0x3C with the stop bit driven 0 -> a `STP_ERR` pulse and no `DATA_VALID`.
- P=8, line low for 3 cycles then high -> no pulses, FSM back in IDLE. Then a valid 0x5A frame -> `DATA_VALID` with `P_DATA`=0x5A.
- P=16, `PAR_EN`=0, frames 0x3C and 0xC3 back-to-back with no idle gap -> two `DATA_VALID` strobes exactly 160 cycles apart, carrying 0x3C then 0xC3.
- P=8, a one-cycle inverted spike at phase P/2 of data bit 3 of 0xFF:
  - with `UART_RX_MAJORITY_VOTE_EN` -> `P_DATA`=0xFF;
  - without it -> 0xF7.
  - In the same run, `RST` pulsed mid-frame -> all outputs 0 and no pulse for the aborted frame.
